// File: rtl/gp_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer driving one shared g/p/h cell, LSB-first, one bit per cycle.
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | walking the cell across bits 0..WIDTH-1
// DONE  | result presented, waiting for out_ready
module gp_serial_adder_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             cell_x,
  output logic             cell_y,
  input  logic             cell_g,
  input  logic             cell_p,
  input  logic             cell_h
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt, sum_reg;
  logic             carry, carry_nxt, sum_bit, cout_reg, ovf_reg;
  logic [IW-1:0]    idx;

  assign sum_bit   = cell_h ^ carry;
  assign carry_nxt = cell_g | (cell_p & carry);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign cell_x    = (state == RUN) ? a_reg[idx] : 1'b0;
  assign cell_y    = (state == RUN) ? b_reg[idx] : 1'b0;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

  always_comb begin
    acc_nxt      = acc;
    acc_nxt[idx] = sum_bit;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = RUN;
      RUN:     if (idx == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= carry_nxt;
          // carry still holds the carry into the MSB on the last bit
          if (idx == LAST) begin
            sum_reg  <= acc_nxt;
            cout_reg <= carry_nxt;
            ovf_reg  <= carry ^ carry_nxt;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gp_serial_adder_ctrl.sv
// Directed self-checking bench for gp_serial_adder_ctrl with a behavioural g/p/h cell.
module tb_gp_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] a = '0;
  logic [5:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] sum;
  logic       cout, ovf, busy;
  logic       cell_x, cell_y, cell_g, cell_p, cell_h;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cell_g = cell_x & cell_y;
  assign cell_p = cell_x | cell_y;
  assign cell_h = cell_x ^ cell_y;

  gp_serial_adder_ctrl #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy),
    .cell_x(cell_x), .cell_y(cell_y), .cell_g(cell_g), .cell_p(cell_p), .cell_h(cell_h)
  );

  // Offers one operand pair, records the cell sequence and returns the accept-to-out_valid latency.
  task automatic start_op(input logic [5:0] av, input logic [5:0] bv, input logic cv,
                          output int lat, output logic [5:0] xs, output logic [5:0] ys);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    xs = '0; ys = '0;
    xs[0] = cell_x; ys[0] = cell_y;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid && lat < 6) begin
        xs[lat] = cell_x;
        ys[lat] = cell_y;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    tests_run++;
    if (sum !== 6'h00 || cout !== 1'b0 || ovf !== 1'b0 || cell_x !== 1'b0 || cell_y !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: sum=%h cout=%b ovf=%b cx=%b cy=%b, want 00 0 0 0 0", sum, cout, ovf, cell_x, cell_y);
    end
  endtask

  task automatic test_basic;
    int lat; logic [5:0] xs, ys;
    start_op(6'h2A, 6'h15, 1'b0, lat, xs, ys);
    tests_run++;
    if (lat !== 6) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d edges, want 6", lat);
    end
    tests_run++;
    if (sum !== 6'h3F || cout !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: sum=%h cout=%b ovf=%b, want 3f 0 0", sum, cout, ovf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 6'h3F) begin
      tests_failed++;
      $display("FAIL basic_release: in_ready=%b out_valid=%b sum=%h, want 1 0 3f", in_ready, out_valid, sum);
    end
  endtask

  task automatic test_carry_ovf;
    int lat; logic [5:0] xs, ys;
    start_op(6'h3F, 6'h01, 1'b0, lat, xs, ys);
    tests_run++;
    if (sum !== 6'h00 || cout !== 1'b1 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_cout: sum=%h cout=%b ovf=%b, want 00 1 0", sum, cout, ovf);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    start_op(6'h1F, 6'h01, 1'b0, lat, xs, ys);
    tests_run++;
    if (sum !== 6'h20 || cout !== 1'b0 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL pos_ovf: sum=%h cout=%b ovf=%b, want 20 0 1", sum, cout, ovf);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    start_op(6'h20, 6'h20, 1'b1, lat, xs, ys);
    tests_run++;
    if (sum !== 6'h01 || cout !== 1'b1 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL neg_ovf_cin: sum=%h cout=%b ovf=%b, want 01 1 1", sum, cout, ovf);
    end
    tests_run++;
    if (xs !== 6'h20 || ys !== 6'h20) begin
      tests_failed++;
      $display("FAIL cell_seq: x=%b y=%b, want 100000 100000", xs, ys);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    start_op(6'h15, 6'h0A, 1'b1, lat, xs, ys);
    tests_run++;
    if (xs !== 6'h15 || ys !== 6'h0A || sum !== 6'h20 || cout !== 1'b0 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL cell_seq2: x=%b y=%b sum=%h cout=%b ovf=%b, want 010101 001010 20 0 1", xs, ys, sum, cout, ovf);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat; logic [5:0] xs, ys;
    int bad;
    start_op(6'h11, 6'h22, 1'b0, lat, xs, ys);
    bad = 0;
    @(negedge clk);
    a = 6'h01; b = 6'h02; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 6'h33 || cout !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0 (last out_valid=%b in_ready=%b sum=%h)", bad, out_valid, in_ready, sum);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || sum !== 6'h33) begin
      tests_failed++;
      $display("FAIL bp_no_accept: busy=%b sum=%h, want 0 33", busy, sum);
    end
  endtask

  task automatic test_abort;
    int lat; int seen; logic [5:0] xs, ys;
    @(negedge clk);
    a = 6'h3F; b = 6'h3F; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    tests_run++;
    if (sum !== 6'h00 || cout !== 1'b0 || ovf !== 1'b0 || cell_x !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_out: sum=%h cout=%b ovf=%b cx=%b, want 00 0 0 0", sum, cout, ovf, cell_x);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL abort_no_valid: out_valid seen %0d cycles, want 0", seen);
    end
    start_op(6'h01, 6'h01, 1'b0, lat, xs, ys);
    tests_run++;
    if (lat !== 6 || sum !== 6'h02 || cout !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_recover: lat=%0d sum=%h cout=%b ovf=%b, want 6 02 0 0", lat, sum, cout, ovf);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [5:0] av, bv, es;
    logic       cv, ec, eo;
    logic [6:0] full;
    int         acc_cyc, prev_cyc, w;
    prev_cyc = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      av = 6'($urandom_range(0, 63));
      bv = 6'($urandom_range(0, 63));
      cv = 1'($urandom_range(0, 1));
      full = {1'b0, av} + {1'b0, bv} + {6'b0, cv};
      es = full[5:0];
      ec = full[6];
      eo = (av[5] == bv[5]) && (es[5] != av[5]);
      @(negedge clk);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      acc_cyc = cyc;
      @(posedge clk);
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      tests_run++;
      if (out_valid !== 1'b1 || sum !== es || cout !== ec || ovf !== eo) begin
        tests_failed++;
        $display("FAIL b2b_result[%0d]: %h+%h+%b got v=%b sum=%h cout=%b ovf=%b, want 1 %h %b %b",
                 k, av, bv, cv, out_valid, sum, cout, ovf, es, ec, eo);
      end
      if (k > 0) begin
        tests_run++;
        if (acc_cyc - prev_cyc != 8) begin
          tests_failed++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 8", k, acc_cyc - prev_cyc);
        end
      end
      prev_cyc = acc_cyc;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gp_serial_adder_ctrl.md
# gp_serial_adder_ctrl

Bit-serial sequencer that time-shares one single-bit generate/propagate/half-sum cell (g = x&y, p = x|y, h = x^y) to perform a full WIDTH-bit addition with carry-in. It accepts operand pairs over a valid/ready handshake and walks the cell across the bits LSB-first, one bit per cycle. It forms the ripple carry and the sum bit from the cell's g/p/h outputs. The result is returned over a second valid/ready handshake. It sits between the 6-bit adder's operand source and the shared generate cell, as an area-minimal alternative to the fully parallel carry network.

## Interface
- WIDTH, 6, operand/sum width in bits (≥2)
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair a/b/cin is valid
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  A+B+cin modulo 2^WIDTH
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow (carry into MSB XOR cout)
- busy  output  1  high in RUN or DONE
- cell_x  output  1  bit of A driven to the shared cell
- cell_y  output  1  bit of B driven to the shared cell
- cell_g  input  1  cell generate (combinational from cell_x/cell_y)
- cell_p  input  1  cell propagate (x|y)
- cell_h  input  1  cell half-sum (x^y)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch a→a_reg, b→b_reg, cin→carry.
  - clear idx=0 and the sum register.
  - go to RUN.
- RUN:
  - cell_x=a_reg[idx], cell_y=b_reg[idx].
  - Each cycle: sum_reg[idx] ← cell_h ^ carry; carry ← cell_g | (cell_p & carry); idx ← idx+1.
  - When idx==WIDTH-1:
    - capture ovf ← carry_in_to_msb ^ carry_next and cout ← carry_next.
    - set out_valid.
    - go to DONE.
- DONE: out_valid=1; sum/cout/ovf stable. On out_ready, clear out_valid and go to IDLE.
- in_ready=0 in RUN and DONE. Operands offered there are not taken, and no skid buffer is provided.
- cell_x=cell_y=0 outside RUN.
- idx width is clog2(WIDTH). It never wraps past WIDTH-1, and the RUN exit takes priority over the increment.
- sum/cout/ovf keep the last result after the handshake completes. They change only at the next RUN completion.
- Cell inputs are treated as purely combinational. No wait states are inserted for the cell.

## Timing
- Reset, effective at the rst edge, sets:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0, cell_x=cell_y=0, idx=0.
- rst during RUN or DONE aborts the operation. The partial result is discarded and no out_valid pulse is produced.
- Accept at edge T. RUN occupies cycles T+1 … T+WIDTH. out_valid is high from edge T+WIDTH (after the last bit), which is WIDTH cycles of latency.
- With out_ready held high, DONE lasts 1 cycle. The next accept is possible at edge T+WIDTH+2, giving a throughput of 1 op per WIDTH+2 cycles.
- out_valid must not drop without out_ready. sum/cout/ovf must not change while out_valid=1.
- in_valid may deassert without being accepted. No state change occurs in that case.

## Test plan
- Reset then a=0x2A, b=0x15, cin=0 → after 6 RUN cycles: sum=0x3F, cout=0, ovf=0. out_valid rises exactly 6 edges after accept.
- a=0x3F, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x1F, b=0x01, cin=0 → sum=0x20, cout=0, ovf=1.
- a=0x20, b=0x20, cin=1 → sum=0x01, cout=1, ovf=1. Check that cell_x/cell_y follow bit sequence a/b[0..5], one bit per cycle.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Then:
  - out_valid and sum are stable throughout, and in_ready=0.
  - operands offered during this window are not accepted.
  - release out_ready → IDLE next cycle, in_ready=1.
- Assert rst for 1 cycle during RUN bit 3 → no out_valid. IDLE with in_ready=1 next cycle, and all outputs reset to 0. A new op a=0x01, b=0x01 then gives sum=0x02.
- Back-to-back: in_valid held high with 10 random operand pairs and out_ready=1 → each result matches (a+b+cin) mod 64 with the correct cout/ovf. Spacing between accepts is 8 cycles.
